// File: rtl/lbus_master_if.sv
// Command/response and multiplexed local-bus signals of lbus_master.
// The master modport is the controller's view; slave is the requester/target view.
interface lbus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic [15:0] lbus_di_a;
  logic        lbus_wrn;
  logic        lbus_rdn;
  logic [15:0] lbus_do;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, lbus_do,
    output cmd_ready, rsp_valid, rsp_rdata, busy,
    output lbus_di_a, lbus_wrn, lbus_rdn
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, lbus_do,
    input  cmd_ready, rsp_valid, rsp_rdata, busy,
    input  lbus_di_a, lbus_wrn, lbus_rdn
  );
endinterface

// File: rtl/lbus_master.sv
// Single-outstanding master for a multiplexed address/data local bus.
// Phases: ADDR -> WDATA or RDATA -> GAP, each lasting a parameterised count.
module lbus_master #(
  parameter int unsigned ADDR_CYC = 2,
  parameter int unsigned DATA_CYC = 2,
  parameter int unsigned RD_CYC   = 3,
  parameter int unsigned GAP_CYC  = 1
) (
  input  logic         clk,
  input  logic         rst,
  lbus_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_RDATA,
    S_GAP
  } state_t;

  localparam logic [7:0] L_ADDR = 8'(ADDR_CYC - 1);
  localparam logic [7:0] L_DATA = 8'(DATA_CYC - 1);
  localparam logic [7:0] L_RD   = 8'(RD_CYC - 1);
  localparam logic [7:0] L_GAP  = 8'(GAP_CYC - 1);

  state_t      r_state;
  state_t      w_state_n;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_n;
  logic        r_we;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_di_a;
  logic        r_wrn;
  logic        r_rdn;
  logic        r_rsp;
  logic [15:0] r_rdata;
  logic [15:0] w_di_n;
  logic        w_wrn_n;
  logic        w_rdn_n;
  logic        w_acc;
  logic        w_last;

  assign w_acc  = bus.cmd_valid & bus.cmd_ready;
  assign w_last = (r_cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // Counter holds the remaining cycles of the current phase.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_state_n = S_ADDR;
          w_cnt_n   = L_ADDR;
        end
      end
      S_ADDR: begin
        if (w_last) begin
          w_state_n = r_we ? S_WDATA : S_RDATA;
          w_cnt_n   = r_we ? L_DATA : L_RD;
        end else begin
          w_cnt_n = r_cnt - 8'd1;
        end
      end
      S_WDATA, S_RDATA: begin
        if (w_last) begin
          w_state_n = S_GAP;
          w_cnt_n   = L_GAP;
        end else begin
          w_cnt_n = r_cnt - 8'd1;
        end
      end
      S_GAP: begin
        if (w_last) begin
          w_state_n = S_IDLE;
          w_cnt_n   = 8'd0;
        end else begin
          w_cnt_n = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = 8'd0;
      end
    endcase
  end

  // Bus values for the next cycle; the address comes straight
  // from the command only on the accepting edge.
  always_comb begin
    w_di_n  = 16'h0000;
    w_wrn_n = 1'b1;
    w_rdn_n = 1'b1;
    unique case (1'b1)
      (w_state_n == S_ADDR):  w_di_n = w_acc ? bus.cmd_addr : r_addr;
      (w_state_n == S_WDATA): begin
        w_di_n  = r_wdata;
        w_wrn_n = 1'b0;
      end
      (w_state_n == S_RDATA): begin
        w_di_n  = r_addr;
        w_rdn_n = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
      r_di_a  <= 16'h0000;
      r_wrn   <= 1'b1;
      r_rdn   <= 1'b1;
      r_rsp   <= 1'b0;
      r_rdata <= 16'h0000;
    end else begin
      if (w_acc) begin
        r_we    <= bus.cmd_we;
        r_addr  <= bus.cmd_addr;
        r_wdata <= bus.cmd_wdata;
      end
      r_di_a <= w_di_n;
      r_wrn  <= w_wrn_n;
      r_rdn  <= w_rdn_n;
      r_rsp  <= (w_state_n == S_GAP) && (r_state != S_GAP);
      if (r_state == S_RDATA && w_last) begin
        r_rdata <= bus.lbus_do;
      end else if (r_state == S_WDATA && w_last) begin
        r_rdata <= 16'h0000;
      end
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE) & ~rst;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.rsp_valid = r_rsp & ~rst;
  assign bus.rsp_rdata = r_rdata;
  assign bus.lbus_di_a = r_di_a;
  assign bus.lbus_wrn  = r_wrn;
  assign bus.lbus_rdn  = r_rdn;

endmodule

// File: tb/tb_lbus_master.sv
// Bench for lbus_master: per-cycle bus timeline model plus response scoreboard,
// with a second 1/1/1/1 instance exercised by directed transactions.
module tb_lbus_master;
  localparam int AC = 2;
  localparam int DC = 2;
  localparam int RC = 3;
  localparam int GC = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst1 = 1'b1;
  always #5 clk = ~clk;

  lbus_master_if b0 ();
  lbus_master_if b1 ();

  lbus_master #(.ADDR_CYC(AC), .DATA_CYC(DC), .RD_CYC(RC), .GAP_CYC(GC))
    dut (.clk(clk), .rst(rst), .bus(b0));

  lbus_master #(.ADDR_CYC(1), .DATA_CYC(1), .RD_CYC(1), .GAP_CYC(1))
    dut1 (.clk(clk), .rst(rst1), .bus(b1));

  typedef struct {
    logic [15:0] di;
    logic        wrn;
    logic        rdn;
    logic        rsp;
    logic        cap;
  } beat_t;

  typedef struct {
    logic        we;
    logic [15:0] rdata;
    int          due;
  } rsp_t;

  beat_t       trace[$];
  rsp_t        rspq[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] held = 16'h0000;
  logic [15:0] cur_rd = 16'h0000;
  bit          chk_en = 1'b0;
  int          dut_acc = 0;
  int          dut_last = -100;
  int          dut_gap = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input int n, input logic [15:0] di,
                            input logic wrn, input logic rdn,
                            input bit rsp_first, input bit cap_last);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.di  = di;
      b.wrn = wrn;
      b.rdn = rdn;
      b.rsp = rsp_first && (i == 0);
      b.cap = cap_last && (i == n - 1);
      trace.push_back(b);
    end
  endtask

  // Reference timeline: one entry per future cycle of the transaction.
  always @(posedge clk) begin
    bit    empty;
    beat_t b;
    rsp_t  r;
    empty = (trace.size() == 0);
    if (!empty) begin
      b = trace.pop_front();
      if (b.cap) begin
        cur_rd = b0.lbus_do;
        if (rspq.size() > 0) rspq[0].rdata = b0.lbus_do;
      end
      if (b.rsp) held = cur_rd;
    end
    if (rst) begin
      trace.delete();
      rspq.delete();
      held = 16'h0000;
    end else if (empty && b0.cmd_valid) begin
      push_beats(AC, b0.cmd_addr, 1'b1, 1'b1, 1'b0, 1'b0);
      if (b0.cmd_we) begin
        cur_rd = 16'h0000;
        push_beats(DC, b0.cmd_wdata, 1'b0, 1'b1, 1'b0, 1'b0);
      end else begin
        push_beats(RC, b0.cmd_addr, 1'b1, 1'b0, 1'b0, 1'b1);
      end
      push_beats(GC, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
      r.we    = b0.cmd_we;
      r.rdata = 16'h0000;
      r.due   = cyc + AC + (b0.cmd_we ? DC : RC) + 1;
      rspq.push_back(r);
    end
    cyc++;
  end

  // Per-cycle bus check and response scoreboard monitor.
  always @(negedge clk) begin
    bit    has;
    beat_t e;
    rsp_t  r;
    if (chk_en) begin
      has = (trace.size() > 0);
      if (has) e = trace[0];
      else begin
        e.di = 16'h0000; e.wrn = 1'b1; e.rdn = 1'b1;
        e.rsp = 1'b0; e.cap = 1'b0;
      end
      chk("di_a", b0.lbus_di_a, e.di);
      chk("wrn", b0.lbus_wrn, e.wrn);
      chk("rdn", b0.lbus_rdn, e.rdn);
      chk("busy", b0.busy, has);
      chk("cmd_ready", b0.cmd_ready, !has && !rst);
      chk("rsp_valid", b0.rsp_valid, has && e.rsp && !rst);
      chk("rsp_rdata", b0.rsp_rdata, (has && e.rsp) ? cur_rd : held);
      chk("strobe_excl", b0.lbus_wrn | b0.lbus_rdn, 1);
      if (rspq.size() > 0 && rspq[0].due < cyc) begin
        chk("rsp_missing", 0, 1);
        void'(rspq.pop_front());
      end
      if (b0.rsp_valid === 1'b1) begin
        if (rspq.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          r = rspq.pop_front();
          chk("rsp_cycle", cyc, r.due);
          chk("rsp_data", b0.rsp_rdata, r.we ? 16'h0000 : r.rdata);
        end
      end
      if (b0.cmd_valid && b0.cmd_ready === 1'b1) begin
        dut_gap  = cyc - dut_last;
        dut_last = cyc;
        dut_acc++;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && trace.size() > 0; i++) tick();
    chk("idle_timeout", trace.size(), 0);
  endtask

  task automatic noise_until_idle();
    for (int i = 0; i < 100 && trace.size() > 0; i++) begin
      tick();
      b0.cmd_valid = (trace.size() > 0) ? 1'($urandom_range(1)) : 1'b0;
      b0.cmd_addr  = 16'($urandom);
      b0.cmd_wdata = 16'($urandom);
      b0.cmd_we    = 1'($urandom_range(1));
    end
    b0.cmd_valid = 1'b0;
  endtask

  task automatic main_seq();
    int n0;
    b0.cmd_valid = 1'b0; b0.cmd_we = 1'b0;
    b0.cmd_addr = 16'h0; b0.cmd_wdata = 16'h0; b0.lbus_do = 16'h0;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    // write 0x0002 <- 0x0001, with noisy requests during busy
    b0.cmd_valid = 1'b1; b0.cmd_we = 1'b1;
    b0.cmd_addr = 16'h0002; b0.cmd_wdata = 16'h0001;
    tick();
    b0.cmd_valid = 1'b0;
    noise_until_idle();
    tick();
    // read 0x0C00 with target data held
    b0.lbus_do = 16'hBEEF;
    b0.cmd_valid = 1'b1; b0.cmd_we = 1'b0; b0.cmd_addr = 16'h0C00;
    tick();
    b0.cmd_valid = 1'b0;
    noise_until_idle();
    tick();
    // back-to-back: valid held, write then read
    b0.cmd_valid = 1'b1; b0.cmd_we = 1'b1;
    b0.cmd_addr = 16'h1234; b0.cmd_wdata = 16'h5678;
    n0 = dut_acc;
    for (int i = 0; i < 20 && dut_acc == n0; i++) tick();
    b0.cmd_we = 1'b0; b0.cmd_addr = 16'h4321;
    n0 = dut_acc;
    for (int i = 0; i < 20 && dut_acc == n0; i++) tick();
    b0.cmd_valid = 1'b0;
    chk("b2b_gap", dut_gap, AC + DC + GC + 1);
    wait_idle();
    tick();
    // reset in cycle 3 of a write
    b0.cmd_valid = 1'b1; b0.cmd_we = 1'b1;
    b0.cmd_addr = 16'hA5A5; b0.cmd_wdata = 16'h5A5A;
    tick();
    b0.cmd_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    // random traffic
    for (int i = 0; i < 400; i++) begin
      tick();
      b0.cmd_valid = ($urandom_range(2) == 0);
      b0.cmd_we    = 1'($urandom_range(1));
      b0.cmd_addr  = 16'($urandom);
      b0.cmd_wdata = 16'($urandom);
      b0.lbus_do   = 16'($urandom);
      rst          = ($urandom_range(149) == 0);
    end
    tick();
    b0.cmd_valid = 1'b0;
    rst = 1'b0;
    wait_idle();
    tick(); tick(); tick();
    chk("rsp_drained", rspq.size(), 0);
  endtask

  task automatic p1_seq();
    logic        we;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] rd;
    int          lowcnt;
    b1.cmd_valid = 1'b0; b1.cmd_we = 1'b0;
    b1.cmd_addr = 16'h0; b1.cmd_wdata = 16'h0; b1.lbus_do = 16'h0;
    tick(); tick();
    rst1 = 1'b0;
    @(negedge clk);
    chk("p1_ready", b1.cmd_ready, 1);
    for (int k = 0; k < 4; k++) begin
      we = k[0];
      a  = 16'($urandom);
      d  = 16'($urandom);
      rd = 16'($urandom);
      tick();
      b1.cmd_valid = 1'b1; b1.cmd_we = we;
      b1.cmd_addr = a; b1.cmd_wdata = d; b1.lbus_do = rd;
      tick();
      b1.cmd_valid = 1'b0;
      b1.cmd_addr  = ~a;
      lowcnt = 0;
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        if (b1.lbus_rdn === 1'b0) lowcnt++;
        if (c == 1) begin
          chk("p1_addr_di", b1.lbus_di_a, a);
          chk("p1_addr_wrn", b1.lbus_wrn, 1);
        end else if (c == 2) begin
          chk("p1_data_di", b1.lbus_di_a, we ? d : a);
          chk("p1_data_wrn", b1.lbus_wrn, !we);
          chk("p1_data_rdn", b1.lbus_rdn, we);
        end else if (c == 3) begin
          chk("p1_rsp_valid", b1.rsp_valid, 1);
          chk("p1_rsp_rdata", b1.rsp_rdata, we ? 16'h0000 : rd);
          chk("p1_gap_di", b1.lbus_di_a, 0);
        end else begin
          chk("p1_ready_back", b1.cmd_ready, 1);
          chk("p1_rsp_once", b1.rsp_valid, 0);
        end
      end
      chk("p1_rdn_low", lowcnt, we ? 0 : 1);
    end
  endtask

  initial begin
    fork
      main_seq();
      p1_seq();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lbus_master.md
LBUS_MASTER -- requirements
Module: lbus_master

Interface
REQ-001 SHALL have parameter ADDR_CYC, default 2: cycles the address is driven with lbus_wrn high.
REQ-002 SHALL have parameter DATA_CYC, default 2: cycles write data is driven with lbus_wrn low.
REQ-003 SHALL have parameter RD_CYC, default 3: cycles lbus_rdn is held low on a read.
REQ-004 SHALL have parameter GAP_CYC, default 1: idle cycles after every transaction; each parameter is 1..255.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port cmd_valid, input, 1: command request.
REQ-008 SHALL have port cmd_ready, output, 1: command accepted when high together with cmd_valid.
REQ-009 SHALL have port cmd_we, input, 1: 1 = write, 0 = read.
REQ-010 SHALL have port cmd_addr, input, 16: bus address.
REQ-011 SHALL have port cmd_wdata, input, 16: write data.
REQ-012 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata, output, 16: read data, valid with rsp_valid.
REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-015 SHALL have port lbus_di_a, output, 16: multiplexed address/data toward the target.
REQ-016 SHALL have port lbus_wrn, output, 1: high = address phase, low = data phase.
REQ-017 SHALL have port lbus_rdn, output, 1: active-low read strobe.
REQ-018 SHALL have port lbus_do, input, 16: read data from the target.

Function
REQ-019 SHALL implement the states IDLE, ADDR, WDATA, RDATA and GAP, with an 8-bit phase counter.
REQ-020 SHALL drive cmd_ready high only in IDLE while rst is low; a command is accepted on the edge where cmd_valid and cmd_ready are both high, and cmd_addr, cmd_we and cmd_wdata are registered on that edge.
REQ-021 SHALL, when a command is accepted at cycle T, drive lbus_di_a = addr and lbus_wrn = 1 (ADDR) for cycles T+1..T+ADDR_CYC.
REQ-022 SHALL, for a write, then drive lbus_di_a = wdata and lbus_wrn = 0 (WDATA) for DATA_CYC cycles, then enter GAP.
REQ-023 SHALL, for a read, then hold lbus_di_a = addr and lbus_wrn = 1 with lbus_rdn = 0 (RDATA) for RD_CYC cycles, register lbus_do at the end of the last RDATA cycle, then enter GAP.
REQ-024 SHALL, in GAP, drive lbus_wrn = 1, lbus_rdn = 1 and lbus_di_a = 0 for GAP_CYC cycles, then return to IDLE.
REQ-025 SHALL pulse rsp_valid for exactly the first GAP cycle; rsp_rdata SHALL be the captured read data for a read and 0x0000 for a write, and SHALL hold its value until the next rsp_valid.
REQ-026 SHALL never assert lbus_wrn = 0 and lbus_rdn = 0 in the same cycle.
REQ-027 SHALL drive all bus outputs from registers (no combinational path from cmd_* to lbus_*).
REQ-028 SHALL ignore cmd_valid while busy; such a command is neither accepted nor buffered.
REQ-029 SHALL have a write occupancy of ADDR_CYC+DATA_CYC+GAP_CYC cycles and a read occupancy of ADDR_CYC+RD_CYC+GAP_CYC cycles after acceptance; cmd_ready SHALL rise in the cycle after the last GAP cycle.
REQ-030 SHALL accept a new command in the same edge as the first IDLE cycle, so back-to-back transactions are separated only by GAP_CYC idle cycles plus one IDLE cycle.

Reset
REQ-031 SHALL, while rst is high, hold state = IDLE, counter = 0, lbus_di_a = 0x0000, lbus_wrn = 1, lbus_rdn = 1, cmd_ready = 0, rsp_valid = 0, rsp_rdata = 0x0000 and busy = 0.
REQ-032 SHALL, on reset during a transaction, abort it: bus strobes deasserted on the next edge, no rsp_valid for the aborted command, and cmd_ready = 1 in the first cycle after rst falls.

Verification
REQ-033 Write (defaults) cmd_addr=0x0002, cmd_wdata=0x0001 accepted at cycle 0 -> cycles 1-2 lbus_di_a=0x0002 with wrn=1; cycles 3-4 lbus_di_a=0x0001 with wrn=0; cycle 5 rsp_valid=1 with rsp_rdata=0x0000; cycle 6 cmd_ready=1.
REQ-034 Read addr 0x0C00 with lbus_do held at 0xBEEF -> cycles 1-2 address phase; cycles 3-5 rdn=0 and di_a=0x0C00; cycle 6 rsp_valid=1 with rsp_rdata=0xBEEF; cycle 7 cmd_ready=1.
REQ-035 cmd_valid held high for a write followed by a read -> second acceptance exactly 6 cycles after the first, and wrn and rdn never low together.
REQ-036 rst pulsed at cycle 3 of a write -> wrn=1 and rdn=1 on the next edge, no rsp_valid, cmd_ready=1 in the cycle after rst falls.
REQ-037 cmd_valid toggled with changing cmd_addr during busy -> no extra acceptance, and the bus shows only the originally latched address.
REQ-038 Parameters 1/1/1/1 with a read -> rdn low for exactly 1 cycle and rsp_valid at cycle 3 after acceptance.
